// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Grant-select encoding, request bundle and default widths.
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int X0_IDX     = 0;
  localparam int CNT_W      = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating starvation counter for the ALU channel.
// Clear has priority over increment; no inc and no clr holds the value.
module wb_starve_ctr
  import wb_pkg::*;
#(
  parameter int LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  assign at_limit = (cnt == CNT_W'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-producer writeback arbiter driving the register-file write port.
// The registered write doubles as the decode-stage forwarding source.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        starve_cnt_o
);

  // Handshake: a request transfers in the cycle where valid && ready. The
  // producer holds valid/addr/data stable until ready; ready is a function of
  // the valid bits, stall, rst and the starvation count only, never of data.

  wb_src_e           src;
  logic              at_limit;
  logic              starve_inc;
  logic              starve_clr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    src = SRC_NONE;
    if (!rst && !stall) begin
      // mem has priority unless the ALU has been blocked long enough
      if (alu_valid && (!mem_valid || at_limit)) begin
        src = SRC_ALU;
      end else if (mem_valid) begin
        src = SRC_MEM;
      end
    end
  end

  assign alu_ready = (src == SRC_ALU);
  assign mem_ready = (src == SRC_MEM);

  always_comb begin
    sel_addr = mem_addr;
    sel_data = mem_data;
    if (src == SRC_ALU) begin
      sel_addr = alu_addr;
      sel_data = alu_data;
    end
  end

  assign starve_inc = alu_valid && !alu_ready && !stall;
  assign starve_clr = alu_ready;

  wb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .cnt      (starve_cnt_o),
    .at_limit (at_limit)
  );

  // x0 grants are consumed but never reach the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if ((src != SRC_NONE) && (sel_addr != ADDR_W'(X0_IDX))) begin
      wr_en   <= 1'b1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule
